pwm_fade_ctrl: RTL

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_core.sv | 47 ++++
 rtl/pwm_fade_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade controller: FSM state encoding and
// the width of the per-extreme dwell counter.
package pwm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RAMP_UP = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_RAMP_DN = 3'd3,
    ST_HOLD_LO = 3'd4
  } fade_state_t;

  // Dwell counter width; holds 1..255 PWM periods.
  localparam int HOLD_W = 8;

endpackage

// File: rtl/pwm_core.sv
// PWM engine: free-running period counter, end-of-period decode and a
// registered duty comparator. Counter and output are held at zero while
// the controller is not running.
module pwm_core #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [NBITS-1:0] threshold,
  output logic             period_end,
  output logic             pwm_out
);

  localparam logic [NBITS-1:0] CNT_MAX = '1;

  logic [NBITS-1:0] cnt_p0;
  logic             pwm_p1;

  // Stage 0: period counter, wraps naturally at 2^NBITS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
    end else if (!run) begin
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  // Last count of the period; the controller updates duty on this edge.
  assign period_end = run && (cnt_p0 == CNT_MAX);

  // Stage 1: registered comparator, one cycle behind the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_p1 <= 1'b0;
    end else if (!run) begin
      pwm_p1 <= 1'b0;
    end else begin
      pwm_p1 <= (cnt_p0 < threshold);
    end
  end

  assign pwm_out = pwm_p1;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Breathing-LED style fade controller. Ramps the PWM duty between
// min_duty and max_duty by STEP per PWM period, dwelling HOLD_PERIODS
// periods at each extreme. Duty only changes on period boundaries so the
// waveform never glitches mid-period.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int NBITS        = 8,
  parameter int STEP         = 1,
  parameter int HOLD_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NBITS-1:0] min_duty,
  input  logic [NBITS-1:0] max_duty,
  output logic [NBITS-1:0] threshold,
  output logic             pwm_out,
  output logic             period_end,
  output logic [2:0]       state
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_PERIODS);

  fade_state_t       state_r, state_nxt;
  logic [NBITS-1:0]  thr_r, thr_nxt;
  logic [HOLD_W-1:0] hold_r, hold_nxt;
  logic              run;
  logic              degenerate;
  logic [NBITS-1:0]  up_val;
  logic [NBITS-1:0]  dn_val;

  // Saturating increment: sum carried one bit wider so it cannot wrap.
  function automatic logic [NBITS-1:0] sat_up(input logic [NBITS-1:0] val,
                                              input logic [NBITS-1:0] hi);
    logic [NBITS:0]   sum;
    logic [NBITS-1:0] res;
    sum = {1'b0, val} + (NBITS+1)'(STEP);
    if (sum > {1'b0, hi}) res = hi;
    else                  res = sum[NBITS-1:0];
    return res;
  endfunction

  // Saturating decrement: signed difference so it cannot underflow.
  function automatic logic [NBITS-1:0] sat_dn(input logic [NBITS-1:0] val,
                                              input logic [NBITS-1:0] lo);
    logic signed [NBITS+1:0] diff;
    logic [NBITS-1:0]        res;
    diff = $signed({2'b00, val}) - $signed((NBITS+2)'(STEP));
    if (diff < $signed({2'b00, lo})) res = lo;
    else                             res = diff[NBITS-1:0];
    return res;
  endfunction

  assign run        = en && (state_r != ST_IDLE);
  assign degenerate = (min_duty >= max_duty);
  assign up_val     = sat_up(thr_r, max_duty);
  assign dn_val     = sat_dn(thr_r, min_duty);

  pwm_core #(
    .NBITS (NBITS)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .threshold  (thr_r),
    .period_end (period_end),
    .pwm_out    (pwm_out)
  );

  // FSM, duty and dwell-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      thr_r   <= '0;
      hold_r  <= '0;
    end else begin
      state_r <= state_nxt;
      thr_r   <= thr_nxt;
      hold_r  <= hold_nxt;
    end
  end

  // Next-state logic; bounds are only looked at on IDLE exit and at
  // period_end, so mid-period bound changes wait for the next boundary.
  always_comb begin
    state_nxt = state_r;
    thr_nxt   = thr_r;
    hold_nxt  = hold_r;
    if (!en) begin
      state_nxt = ST_IDLE;
      thr_nxt   = '0;
      hold_nxt  = '0;
    end else if (state_r == ST_IDLE) begin
      if (degenerate) begin
        state_nxt = ST_HOLD_HI;
        thr_nxt   = max_duty;
        hold_nxt  = HOLD_LOAD;
      end else begin
        state_nxt = ST_RAMP_UP;
        thr_nxt   = min_duty;
      end
    end else if (period_end) begin
      if (degenerate && (state_r != ST_HOLD_HI)) begin
        // Invalid bounds: park at max_duty until a hold expiry sees them valid.
        state_nxt = ST_HOLD_HI;
        thr_nxt   = max_duty;
        hold_nxt  = HOLD_LOAD;
      end else begin
        case (state_r)
          ST_RAMP_UP: begin
            thr_nxt = up_val;
            if (up_val == max_duty) begin
              state_nxt = ST_HOLD_HI;
              hold_nxt  = HOLD_LOAD;
            end
          end
          ST_HOLD_HI: begin
            if (hold_r <= 1) begin
              if (degenerate) begin
                thr_nxt  = max_duty;
                hold_nxt = HOLD_LOAD;
              end else begin
                state_nxt = ST_RAMP_DN;
                hold_nxt  = '0;
              end
            end else begin
              hold_nxt = hold_r - 1'b1;
            end
          end
          ST_RAMP_DN: begin
            thr_nxt = dn_val;
            if (dn_val == min_duty) begin
              state_nxt = ST_HOLD_LO;
              hold_nxt  = HOLD_LOAD;
            end
          end
          ST_HOLD_LO: begin
            if (hold_r <= 1) begin
              state_nxt = ST_RAMP_UP;
              hold_nxt  = '0;
            end else begin
              hold_nxt = hold_r - 1'b1;
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            thr_nxt   = '0;
            hold_nxt  = '0;
          end
        endcase
      end
    end
  end

  assign threshold = thr_r;
  assign state     = state_r;

endmodule
